pcie_serialiser: RTL and testbench

- Multi-lane 10-bit symbol serialiser/deserialiser for the PCIe virtual host.
- Converts per-lane 10-bit encoded symbols to 1-bit serial streams and back, one bit per SerClk cycle.
- Sits between the parallel host model and the serial link wires.
- Transmit uses one shared 10-cycle frame counter; receive aligns per lane, on K28.5 commas when enabled.

---
 rtl/pcie_serialiser.sv | 114 +++++++++++
 tb/tb_pcie_serialiser.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_serialiser.sv
// Multi-lane 10-bit symbol serialiser/deserialiser with a shared transmit frame counter.
// Optional macro PCIE_SER_COMMA_ALIGN_EN enables per-lane K28.5 comma alignment on receive.
module pcie_serialiser #(
   parameter int unsigned LANES = 16,
   parameter int unsigned SYMW  = 10
) (
   input  logic                    SerClk,
   input  logic                    Reset,
   input  logic                    BitReverse,
   input  logic [LANES*SYMW-1:0]   ParInVec,
   output logic [LANES-1:0]        SerOut,
   input  logic [LANES-1:0]        SerIn,
   output logic [LANES*SYMW-1:0]   ParOut
);

   localparam int unsigned CNTW = $clog2(SYMW);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SYMW - 1);
`ifdef PCIE_SER_COMMA_ALIGN_EN
   localparam logic [SYMW-1:0] COMMA_P = SYMW'(10'h17C);
   localparam logic [SYMW-1:0] COMMA_N = SYMW'(10'h283);
`endif

   function automatic logic [SYMW-1:0] bit_rev(input logic [SYMW-1:0] v);
      logic [SYMW-1:0] r;
      r = '0;
      for (int i = 0; i < int'(SYMW); i++) r[i] = v[int'(SYMW) - 1 - i];
      return r;
   endfunction

   logic [CNTW-1:0]                tx_cnt;
   logic [LANES-1:0][SYMW-1:0]     tx_shift;
   logic [LANES-1:0][SYMW-1:0]     rx_shift;
   logic [LANES-1:0][SYMW-1:0]     rx_win;
   logic [LANES-1:0][SYMW-1:0]     rx_sym;

   // Transmit: load every symbol on the frame boundary, otherwise shift out LSB first
   always_ff @(posedge SerClk) begin
      if (Reset) begin
         tx_cnt   <= '0;
         tx_shift <= '0;
      end else begin
         tx_cnt <= (tx_cnt == CNT_LAST) ? '0 : tx_cnt + CNTW'(1);
         for (int n = 0; n < int'(LANES); n++) begin
            if (tx_cnt == '0)
               tx_shift[n] <= BitReverse ? bit_rev(ParInVec[n*SYMW +: SYMW])
                                         : ParInVec[n*SYMW +: SYMW];
            else
               tx_shift[n] <= {1'b0, tx_shift[n][SYMW-1:1]};
         end
      end
   end

   always_comb begin
      SerOut = '0;
      for (int n = 0; n < int'(LANES); n++) SerOut[n] = tx_shift[n][0];
   end

   // Receive window: newest bit enters at the top, oldest sits at bit 0
   always_comb begin
      rx_win = '0;
      rx_sym = '0;
      for (int n = 0; n < int'(LANES); n++) begin
         rx_win[n] = {SerIn[n], rx_shift[n][SYMW-1:1]};
         rx_sym[n] = BitReverse ? bit_rev(rx_win[n]) : rx_win[n];
      end
   end

`ifdef PCIE_SER_COMMA_ALIGN_EN
   logic [LANES-1:0][CNTW-1:0]     rx_cnt;
   logic [LANES-1:0]               rx_lock;

   // A comma always realigns the lane, even in the middle of a framed symbol
   always_ff @(posedge SerClk) begin
      if (Reset) begin
         rx_shift <= '0;
         rx_cnt   <= '0;
         rx_lock  <= '0;
         ParOut   <= '0;
      end else begin
         for (int n = 0; n < int'(LANES); n++) begin
            rx_shift[n] <= rx_win[n];
            if (rx_sym[n] == COMMA_P || rx_sym[n] == COMMA_N) begin
               ParOut[n*SYMW +: SYMW] <= rx_sym[n];
               rx_cnt[n]              <= '0;
               rx_lock[n]             <= 1'b1;
            end else if (rx_lock[n] && rx_cnt[n] == CNT_LAST) begin
               ParOut[n*SYMW +: SYMW] <= rx_sym[n];
               rx_cnt[n]              <= '0;
            end else begin
               rx_cnt[n] <= (rx_cnt[n] == CNT_LAST) ? '0 : rx_cnt[n] + CNTW'(1);
            end
         end
      end
   end
`else
   logic [CNTW-1:0]                rx_cnt;

   // Without comma detection all lanes share one framing fixed by reset
   always_ff @(posedge SerClk) begin
      if (Reset) begin
         rx_shift <= '0;
         rx_cnt   <= '0;
         ParOut   <= '0;
      end else begin
         rx_cnt <= (rx_cnt == CNT_LAST) ? '0 : rx_cnt + CNTW'(1);
         for (int n = 0; n < int'(LANES); n++) begin
            rx_shift[n] <= rx_win[n];
            if (rx_cnt == CNT_LAST) ParOut[n*SYMW +: SYMW] <= rx_sym[n];
         end
      end
   end
`endif

endmodule

// File: tb/tb_pcie_serialiser.sv
// Self-checking bench for pcie_serialiser; the reference model works from bit histories.
// Build with PCIE_SER_COMMA_ALIGN_EN defined to exercise comma alignment checks.
module tb_pcie_serialiser;

   localparam int unsigned LANES = 16;
   localparam int unsigned SYMW  = 10;

   logic                  SerClk = 1'b0;
   logic                  Reset;
   logic                  BitReverse;
   logic [LANES*SYMW-1:0] ParInVec;
   logic [LANES-1:0]      SerIn;
   logic [LANES-1:0]      SerOut;
   logic [LANES*SYMW-1:0] ParOut;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int                    edges;
   logic [LANES-1:0]      exp_ser;
   logic [LANES*SYMW-1:0] exp_par;
   logic [SYMW-1:0]       tx_sym [LANES];
   logic                  tx_rev;
   logic [LANES-1:0]      hist [$];
`ifdef PCIE_SER_COMMA_ALIGN_EN
   int                    since [LANES];
   bit                    locked [LANES];
`endif

   pcie_serialiser #(.LANES(LANES), .SYMW(SYMW)) dut (
      .SerClk     (SerClk),
      .Reset      (Reset),
      .BitReverse (BitReverse),
      .ParInVec   (ParInVec),
      .SerOut     (SerOut),
      .SerIn      (SerIn),
      .ParOut     (ParOut)
   );

   always #5 SerClk = ~SerClk;

   function automatic logic [SYMW-1:0] rev10(input logic [SYMW-1:0] v);
      logic [SYMW-1:0] r;
      for (int i = 0; i < int'(SYMW); i++) r[i] = v[int'(SYMW) - 1 - i];
      return r;
   endfunction

   // Advance the model by one clock edge using the inputs the bench is driving
   task automatic model_edge();
      logic [SYMW-1:0] w;
      logic [SYMW-1:0] s;
      int k;
      if (Reset) begin
         edges   = 0;
         exp_ser = '0;
         exp_par = '0;
         hist.delete();
         repeat (SYMW) hist.push_back('0);
`ifdef PCIE_SER_COMMA_ALIGN_EN
         for (int n = 0; n < int'(LANES); n++) begin
            since[n]  = 0;
            locked[n] = 1'b0;
         end
`endif
      end else begin
         edges++;
         hist.push_back(SerIn);
         void'(hist.pop_front());
         for (int n = 0; n < int'(LANES); n++) begin
            for (int i = 0; i < int'(SYMW); i++) w[i] = hist[i][n];
            s = BitReverse ? rev10(w) : w;
`ifdef PCIE_SER_COMMA_ALIGN_EN
            if (s == 10'h17C || s == 10'h283) begin
               exp_par[n*SYMW +: SYMW] = s;
               since[n]  = 0;
               locked[n] = 1'b1;
            end else if (locked[n] && since[n] == 9) begin
               exp_par[n*SYMW +: SYMW] = s;
               since[n] = 0;
            end else begin
               since[n] = (since[n] + 1) % 10;
            end
`else
            if (edges % 10 == 0) exp_par[n*SYMW +: SYMW] = s;
`endif
         end
         k = (edges - 1) % 10;
         if (k == 0) begin
            for (int n = 0; n < int'(LANES); n++) tx_sym[n] = ParInVec[n*SYMW +: SYMW];
            tx_rev = BitReverse;
         end
         for (int n = 0; n < int'(LANES); n++)
            exp_ser[n] = tx_rev ? tx_sym[n][9-k] : tx_sym[n][k];
      end
   endtask

   task automatic step();
      @(posedge SerClk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
   endtask

   task automatic rand_par();
      for (int n = 0; n < int'(LANES); n++) ParInVec[n*SYMW +: SYMW] = 10'($urandom);
   endtask

   task automatic test_reset();
      Reset      = 1'b1;
      BitReverse = 1'b0;
      rand_par();
      SerIn = 16'($urandom);
      repeat (3) step();
      checks++;
      if (SerOut !== 16'h0000) begin
         failures++;
         $display("FAIL reset_serout got=%h exp=0000", SerOut);
      end
      checks++;
      if (ParOut !== '0) begin
         failures++;
         $display("FAIL reset_parout got=%h exp=0", ParOut);
      end
      Reset = 1'b0;
      SerIn = '0;
      ParInVec[0 +: SYMW] = 10'h2AA;
      step();
      checks++;
      if (SerOut !== exp_ser || SerOut[0] !== 1'b0) begin
         failures++;
         $display("FAIL reset_first_load got=%h exp=%h", SerOut, exp_ser);
      end
   endtask

   task automatic test_tx_order(input logic rev, input int lane, input logic [SYMW-1:0] sym,
                                input logic [SYMW-1:0] seq);
      do_reset();
      BitReverse = rev;
      rand_par();
      ParInVec[lane*SYMW +: SYMW] = sym;
      for (int i = 0; i < 10; i++) begin
         step();
         rand_par();
         checks++;
         if (SerOut[lane] !== seq[i]) begin
            failures++;
            $display("FAIL tx_order rev=%0d lane=%0d bit=%0d got=%b exp=%b", rev, lane, i, SerOut[lane], seq[i]);
         end
         checks++;
         if (SerOut !== exp_ser) begin
            failures++;
            $display("FAIL tx_all cyc=%0d got=%h exp=%h", i, SerOut, exp_ser);
         end
      end
   endtask

   task automatic test_loopback();
      logic [SYMW-1:0] syms [3];
      syms = '{10'h17C, 10'h0F0, 10'h155};
      do_reset();
      BitReverse = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if ((c - 1) % 10 == 0) begin
            rand_par();
            if (c <= 21) ParInVec[0 +: SYMW] = syms[(c-1)/10];
         end
         SerIn = exp_ser;
         step();
         checks++;
         if (SerOut !== exp_ser || ParOut !== exp_par) begin
            failures++;
            $display("FAIL loopback cyc=%0d ser=%h/%h par=%h exp=%h", c, SerOut, exp_ser, ParOut, exp_par);
         end
`ifdef PCIE_SER_COMMA_ALIGN_EN
         if (c == 11 || c == 21 || c == 31) begin
            checks++;
            if (ParOut[0 +: SYMW] !== syms[(c-11)/10]) begin
               failures++;
               $display("FAIL loopback_lane0 cyc=%0d got=%h exp=%h", c, ParOut[0 +: SYMW], syms[(c-11)/10]);
            end
         end
`endif
      end
   endtask

   task automatic test_fixed_framing();
      do_reset();
      BitReverse = 1'b0;
      for (int n = 0; n < int'(LANES); n++) ParInVec[n*SYMW +: SYMW] = 10'(n);
      for (int c = 1; c <= 60; c++) begin
         ParInVec[5*SYMW +: SYMW] = (c == 41) ? 10'h17C : 10'd5;
         SerIn = exp_ser;
         step();
         checks++;
         if (SerOut !== exp_ser || ParOut !== exp_par) begin
            failures++;
            $display("FAIL framing cyc=%0d ser=%h/%h par=%h exp=%h", c, SerOut, exp_ser, ParOut, exp_par);
         end
`ifndef PCIE_SER_COMMA_ALIGN_EN
         // one-bit offset: the window closes one edge before the next load edge
         if (c == 20 || c == 30 || c == 40) begin
            for (int n = 0; n < int'(LANES); n++) begin
               checks++;
               if (ParOut[n*SYMW +: SYMW] !== 10'(2*n)) begin
                  failures++;
                  $display("FAIL framing_lane cyc=%0d lane=%0d got=%h exp=%h", c, n, ParOut[n*SYMW +: SYMW], 10'(2*n));
               end
            end
         end
         if (c == 50 || c == 60) begin
            checks++;
            if (ParOut[5*SYMW +: SYMW] !== ((c == 50) ? 10'h2F8 : 10'h00A)) begin
               failures++;
               $display("FAIL framing_comma cyc=%0d got=%h", c, ParOut[5*SYMW +: SYMW]);
            end
         end
`endif
      end
   endtask

   task automatic test_realign();
      logic [SYMW-1:0] comma;
      logic [SYMW-1:0] data;
      comma = 10'h283;
      data  = 10'h1A5;
      do_reset();
      BitReverse = 1'b0;
      SerIn = '0;
      for (int c = 0; c < 35; c++) begin
         if (c >= 12 && c < 15) SerIn[7] = 1'($urandom);
         else if (c >= 15 && c < 25) SerIn[7] = comma[c-15];
         else if (c >= 25) SerIn[7] = data[c-25];
         else SerIn[7] = 1'b0;
         step();
         checks++;
         if (ParOut !== exp_par || SerOut !== exp_ser) begin
            failures++;
            $display("FAIL realign cyc=%0d par=%h exp=%h", c, ParOut, exp_par);
         end
`ifdef PCIE_SER_COMMA_ALIGN_EN
         if (c >= 24) begin
            checks++;
            if (ParOut[7*SYMW +: SYMW] !== ((c == 34) ? data : comma)) begin
               failures++;
               $display("FAIL realign_lane7 cyc=%0d got=%h exp=%h", c, ParOut[7*SYMW +: SYMW], (c == 34) ? data : comma);
            end
         end
`endif
      end
   endtask

   task automatic test_random_loopback(input logic rev);
      do_reset();
      BitReverse = rev;
      for (int c = 1; c <= 200; c++) begin
         rand_par();
         for (int n = 0; n < int'(LANES); n++)
            if ($urandom_range(3) == 0) ParInVec[n*SYMW +: SYMW] = $urandom_range(1) ? 10'h17C : 10'h283;
         // mid-symbol reset aborts both directions
         Reset = (c == 105);
         SerIn = exp_ser;
         step();
         checks++;
         if (SerOut !== exp_ser || ParOut !== exp_par) begin
            failures++;
            $display("FAIL random_loop rev=%0d cyc=%0d ser=%h/%h par=%h exp=%h", rev, c, SerOut, exp_ser, ParOut, exp_par);
         end
      end
      Reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tx_order(1'b0, 0, 10'h2AA, 10'b10_1010_1010);
      test_tx_order(1'b1, 3, 10'h17C, 10'b00_1111_1010);
      test_loopback();
      test_fixed_framing();
      test_realign();
      test_random_loopback(1'b0);
      test_random_loopback(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
